// File: rtl/dafx_cfg_master.sv
// Register-access initiator for the dafx configuration space: turns single
// read/write commands into AXI4-Lite transactions with decode and timeout checks.
module dafx_cfg_master #(
  parameter int AXI_ADDR_WIDTH_P = 16,
  parameter int AXI_DATA_WIDTH_P = 64,
  parameter logic [AXI_ADDR_WIDTH_P-1:0] HIGH_ADDRESS_P = 'h0090,
  parameter int TIMEOUT_P = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH_P-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH_P-1:0]   cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXI_DATA_WIDTH_P-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_status,
  output logic                          busy,
  output logic [AXI_ADDR_WIDTH_P-1:0]   cfg_awaddr,
  output logic                          cfg_awvalid,
  input  logic                          cfg_awready,
  output logic [AXI_DATA_WIDTH_P-1:0]   cfg_wdata,
  output logic [AXI_DATA_WIDTH_P/8-1:0] cfg_wstrb,
  output logic                          cfg_wvalid,
  input  logic                          cfg_wready,
  input  logic [1:0]                    cfg_bresp,
  input  logic                          cfg_bvalid,
  output logic                          cfg_bready,
  output logic [AXI_ADDR_WIDTH_P-1:0]   cfg_araddr,
  output logic                          cfg_arvalid,
  input  logic                          cfg_arready,
  input  logic [AXI_DATA_WIDTH_P-1:0]   cfg_rdata,
  input  logic [1:0]                    cfg_rresp,
  input  logic                          cfg_rvalid,
  output logic                          cfg_rready
);

  localparam int STRB_W = AXI_DATA_WIDTH_P / 8;
  localparam logic [AXI_ADDR_WIDTH_P-1:0] ALIGN_MASK = AXI_ADDR_WIDTH_P'(STRB_W - 1);
  localparam int TMR_W = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_P - 1);

  localparam logic [1:0] ST_OKAY    = 2'b00;
  localparam logic [1:0] ST_DECODE  = 2'b01;
  localparam logic [1:0] ST_BUS     = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP
  } state_t;

  state_t state, state_d;

  logic                        aw_done, aw_done_d;
  logic                        w_done, w_done_d;
  logic [1:0]                  status, status_d;
  logic [AXI_DATA_WIDTH_P-1:0] rdata, rdata_d;
  logic [TMR_W-1:0]            timer;
  logic                        load_wr, load_rd;
  logic                        legal, timed_out, in_wait;
  logic                        aw_hs, w_hs;

  assign legal     = (cmd_addr < HIGH_ADDRESS_P) && ((cmd_addr & ALIGN_MASK) == '0);
  assign timed_out = (timer == TMR_LAST);
  assign in_wait   = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_DATA);

  // AXI outputs are decoded purely from registered state so no slave input
  // can reach a master output combinationally.
  assign cfg_awvalid = (state == WR_REQ) && !aw_done;
  assign cfg_wvalid  = (state == WR_REQ) && !w_done;
  assign cfg_bready  = (state == WR_RESP);
  assign cfg_arvalid = (state == RD_REQ);
  assign cfg_rready  = (state == RD_DATA);
  assign aw_hs       = cfg_awvalid && cfg_awready;
  assign w_hs        = cfg_wvalid && cfg_wready;

  assign cmd_ready  = (state == IDLE) && rst_n;
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);
  assign rsp_status = status;
  assign rsp_rdata  = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // A handshake is always tested before the timeout, so a late handshake wins.
  always_comb begin
    state_d   = state;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    status_d  = status;
    rdata_d   = rdata;
    load_wr   = 1'b0;
    load_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          if (!legal) begin
            status_d = ST_DECODE;
            state_d  = RESP;
          end else begin
            status_d = ST_OKAY;
            load_wr  = cmd_write;
            load_rd  = !cmd_write;
            state_d  = cmd_write ? WR_REQ : RD_REQ;
          end
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done || aw_hs;
        w_done_d  = w_done || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end else if (timed_out) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end
      end
      WR_RESP: begin
        if (cfg_bvalid) begin
          status_d = (cfg_bresp == 2'b00) ? ST_OKAY : ST_BUS;
          state_d  = RESP;
        end else if (timed_out) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end
      end
      RD_REQ: begin
        if (cfg_arready) begin
          state_d = RD_DATA;
        end else if (timed_out) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end
      end
      RD_DATA: begin
        if (cfg_rvalid) begin
          rdata_d  = cfg_rdata;
          status_d = (cfg_rresp == 2'b00) ? ST_OKAY : ST_BUS;
          state_d  = RESP;
        end else if (timed_out) begin
          rdata_d  = '0;
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      status     <= ST_OKAY;
      rdata      <= '0;
      timer      <= '0;
      cfg_awaddr <= '0;
      cfg_wdata  <= '0;
      cfg_wstrb  <= '0;
      cfg_araddr <= '0;
    end else begin
      aw_done <= aw_done_d;
      w_done  <= w_done_d;
      status  <= status_d;
      rdata   <= rdata_d;
      if (state_d != state) timer <= '0;
      else if (in_wait)     timer <= timer + 1'b1;
      if (load_wr) begin
        cfg_awaddr <= cmd_addr;
        cfg_wdata  <= cmd_wdata;
        cfg_wstrb  <= '1;
      end
      if (load_rd) cfg_araddr <= cmd_addr;
    end
  end

endmodule

// File: doc/dafx_cfg_master.md
# dafx_cfg_master

Register-access initiator for the dafx configuration space: accepts single read/write commands on a valid/ready command port and executes them as AXI4-Lite transactions toward the dafx register block. It sits between a host-side command source (UART/SPI command decoder or test sequencer) and the register block's AXI4-Lite slave port. It pre-checks addresses against the register map bounds, bounds every bus wait with a timeout and returns one response per command.

## Interface
- AXI_ADDR_WIDTH_P, 16, address width of command and AXI ports
- AXI_DATA_WIDTH_P, 64, data width; register stride is AXI_DATA_WIDTH_P/8 bytes
- HIGH_ADDRESS_P, 16'h0090, first address outside the register map
- TIMEOUT_P, 255, max cycles spent in any bus-wait state, >= 1

Ports (all AXI names prefixed `cfg_`):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AXI_ADDR_WIDTH_P  byte address
- cmd_wdata  in  AXI_DATA_WIDTH_P  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  AXI_DATA_WIDTH_P  read data, 0 for writes/errors
- rsp_status  out  2  00 OKAY, 01 local decode error, 10 bus SLVERR/DECERR, 11 timeout
- busy  out  1  high in any state other than IDLE
- cfg_awaddr/awvalid/awready, cfg_wdata/wstrb/wvalid/wready, cfg_bresp/bvalid/bready, cfg_araddr/arvalid/arready, cfg_rdata/rresp/rvalid/rready: standard AXI4-Lite master signals, widths from parameters, wstrb is AXI_DATA_WIDTH_P/8 bits

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- IDLE: cmd_ready = 1 (0 while rst_n low). On cmd_valid: latch write/addr/wdata.
- Address legal iff cmd_addr < HIGH_ADDRESS_P and the low log2(AXI_DATA_WIDTH_P/8) bits are 0. Illegal -> RESP, status 01, no bus activity.
- Legal write -> WR_REQ: awvalid and wvalid both 1; each drops independently after its own handshake; when both done -> WR_RESP. wstrb all ones.
- WR_RESP: bready = 1; on bvalid -> RESP, status = 00 if bresp = 00 else 10.
- Legal read -> RD_REQ: arvalid = 1 until arready -> RD_DATA.
- RD_DATA: rready = 1; on rvalid capture rdata -> RESP, status 00 if rresp = 00 else 10 (rdata still captured).
- RESP: rsp_valid = 1, outputs stable until rsp_ready, then IDLE.
- Timeout: counter cleared on each state entry, increments in WR_REQ/WR_RESP/RD_REQ/RD_DATA; at TIMEOUT_P cycles all AXI valid/ready outputs drop, -> RESP status 11, rsp_rdata 0. Deliberate protocol break for hung-slave recovery.
- Handshake and timeout in same cycle: handshake wins.

## Timing
- Reset values: all AXI valid/ready outputs 0, addr/data/wstrb outputs 0, rsp_valid 0, rsp_status 00, rsp_rdata 0, busy 0, state IDLE.
- All outputs registered or decoded from registered state; no combinational path from AXI inputs to AXI outputs.
- Command accepted at cycle T. Illegal: rsp_valid at T+1.
- Zero-wait slave (ready high, b/rvalid one cycle after request handshake): request valid at T+1, handshake T+1, bready/rready at T+2, response handshake T+2, rsp_valid at T+3. Minimum command-to-response latency 3 cycles.
- Back-to-back: next cmd_ready the cycle after rsp_valid & rsp_ready.
- Reset mid-transaction: immediate return to reset values; in-flight command discarded, no response.

## Test plan
- Write 0x0008 data 0x1234, zero-wait slave -> aw/w at T+1 with wstrb 0xFF, rsp_valid at T+3, status 00, rdata 0.
- Read 0x0088, slave returns 0xCAFE with awready/arready delayed 4 cycles -> rsp_valid 4 cycles later than zero-wait, rdata 0xCAFE, status 00.
- Addresses 0x0090 and 0x0004 -> no AXI valid ever asserted, rsp_valid at T+1, status 01.
- Write with awready at cycle 1, wready at cycle 5 -> awvalid drops after cycle 1, wvalid held to cycle 5; bresp = 10 -> status 10.
- Slave never asserts rvalid, TIMEOUT_P = 16 -> rready drops after 16 cycles in RD_DATA, status 11; next command then completes normally.
- rst_n pulsed low during WR_RESP -> all outputs at reset values immediately, no rsp_valid afterward until new command.
